// File: rtl/simon_draw_ctrl.sv
// Simon Says replay controller: lights, holds, blanks and holds each stored tile in turn.
// Optional macro SIMON_TONE_EN adds the tone_valid/tone_sel outputs.
module simon_draw_ctrl #(
  parameter int unsigned TILE_PIXELS = 16,
  parameter int unsigned ON_TICKS    = 25000000,
  parameter int unsigned OFF_TICKS   = 12500000,
  parameter int unsigned SEQ_MAX     = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       start,
  input  logic [4:0]                 seq_len,
  output logic [$clog2(SEQ_MAX)-1:0] seq_addr,
  input  logic [1:0]                 seq_tile,
  output logic                       busy,
  output logic                       done,
  output logic [7:0]                 x_out,
  output logic [6:0]                 y_out,
  output logic [2:0]                 colour_out,
`ifdef SIMON_TONE_EN
  output logic                       tone_valid,
  output logic [1:0]                 tone_sel,
`endif
  output logic                       plot
);

  localparam int unsigned AW       = $clog2(SEQ_MAX);
  localparam int unsigned LW       = $clog2(SEQ_MAX + 1);
  localparam int unsigned HOLD_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int unsigned CNT_MAX  = (HOLD_MAX > TILE_PIXELS) ? HOLD_MAX : TILE_PIXELS;
  localparam int unsigned CW       = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDrawOn, StHoldOn, StDrawOff, StHoldOff, StDone
  } state_e;

  state_e          r_state, w_state_d;
  logic [CW-1:0]   r_cnt, w_cnt_d;
  logic [AW-1:0]   r_index, w_index_d;
  logic [LW-1:0]   r_len, w_len_d;
  logic [LW-1:0]   w_index_inc;
  logic [7:0]      r_x, w_x_d, w_tile_x;
  logic [6:0]      r_y, w_y_d, w_tile_y;
  logic [2:0]      r_col, w_col_d, w_tile_col;
  logic            r_plot, w_plot_d;
  logic            r_busy, w_busy_d;
  logic            r_done, w_done_d;

  always_comb begin
    w_tile_x   = 8'd40;
    w_tile_y   = 7'd20;
    w_tile_col = 3'b100;
    unique case (seq_tile)
      2'd0: begin w_tile_x = 8'd40;  w_tile_y = 7'd20; w_tile_col = 3'b100; end
      2'd1: begin w_tile_x = 8'd100; w_tile_y = 7'd20; w_tile_col = 3'b010; end
      2'd2: begin w_tile_x = 8'd40;  w_tile_y = 7'd80; w_tile_col = 3'b001; end
      2'd3: begin w_tile_x = 8'd100; w_tile_y = 7'd80; w_tile_col = 3'b110; end
      default: ;
    endcase
  end

  assign w_index_inc = LW'(r_index) + LW'(1);

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_index_d = r_index;
    w_len_d   = r_len;
    w_x_d     = r_x;
    w_y_d     = r_y;
    w_col_d   = r_col;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          if (seq_len != 5'd0) begin
            w_state_d = StFetch;
            w_index_d = '0;
            w_len_d   = (32'(seq_len) > SEQ_MAX) ? LW'(SEQ_MAX) : LW'(seq_len);
          end else begin
            w_state_d = StDone;
          end
        end
      end
      StFetch: begin
        w_state_d = StDrawOn;
        w_cnt_d   = CW'(TILE_PIXELS - 1);
        w_x_d     = w_tile_x;
        w_y_d     = w_tile_y;
        w_col_d   = w_tile_col;
      end
      StDrawOn: begin
        if (r_cnt == '0) begin
          w_state_d = StHoldOn;
          w_cnt_d   = CW'(ON_TICKS - 1);
        end else begin
          w_cnt_d = r_cnt - CW'(1);
        end
      end
      StHoldOn: begin
        if (r_cnt == '0) begin
          w_state_d = StDrawOff;
          w_cnt_d   = CW'(TILE_PIXELS - 1);
          w_col_d   = 3'b000;
        end else begin
          w_cnt_d = r_cnt - CW'(1);
        end
      end
      StDrawOff: begin
        if (r_cnt == '0) begin
          w_state_d = StHoldOff;
          w_cnt_d   = CW'(OFF_TICKS - 1);
        end else begin
          w_cnt_d = r_cnt - CW'(1);
        end
      end
      StHoldOff: begin
        if (r_cnt == '0) begin
          w_index_d = w_index_inc[AW-1:0];
          w_state_d = (w_index_inc == r_len) ? StDone : StFetch;
        end else begin
          w_cnt_d = r_cnt - CW'(1);
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    // Outputs are registered from the next state so they line up with the state they describe.
    w_plot_d = (w_state_d == StDrawOn) || (w_state_d == StDrawOff);
    w_busy_d = (w_state_d != StIdle) && (w_state_d != StDone);
    w_done_d = (w_state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_index <= '0;
      r_len   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_col   <= '0;
      r_plot  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_index <= w_index_d;
      r_len   <= w_len_d;
      r_x     <= w_x_d;
      r_y     <= w_y_d;
      r_col   <= w_col_d;
      r_plot  <= w_plot_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
    end
  end

  assign seq_addr   = r_index;
  assign busy       = r_busy;
  assign done       = r_done;
  assign x_out      = r_x;
  assign y_out      = r_y;
  assign colour_out = r_col;
  assign plot       = r_plot;

`ifdef SIMON_TONE_EN
  logic       r_tone_valid, w_tone_valid_d;
  logic [1:0] r_tone_sel, w_tone_sel_d;

  always_comb begin
    w_tone_valid_d = (w_state_d == StDrawOn) || (w_state_d == StHoldOn);
    w_tone_sel_d   = 2'd0;
    if (w_tone_valid_d) begin
      w_tone_sel_d = (r_state == StFetch) ? seq_tile : r_tone_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_tone_valid <= 1'b0;
      r_tone_sel   <= 2'd0;
    end else begin
      r_tone_valid <= w_tone_valid_d;
      r_tone_sel   <= w_tone_sel_d;
    end
  end

  assign tone_valid = r_tone_valid;
  assign tone_sel   = r_tone_sel;
`endif

endmodule
